// File: rtl/reg_bank_if.sv
// Write-back / clear-request bus between the datapath and the MIPS register bank.
// The master drives writes and clear requests; the slave returns status and the flat register bus.
interface reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int N_REGS = 32,
    parameter int ADDR_W = 5
);
    logic                     WrEn;
    logic [ADDR_W-1:0]        WrAddr;
    logic [DATA_W-1:0]        WrData;
    logic                     ClrReq;
    logic                     Busy;
    logic                     WrDrop;
    logic [N_REGS*DATA_W-1:0] RegsOut;

    modport master (
        output WrEn, WrAddr, WrData, ClrReq,
        input  Busy, WrDrop, RegsOut
    );

    modport slave (
        input  WrEn, WrAddr, WrData, ClrReq,
        output Busy, WrDrop, RegsOut
    );
endinterface

// File: rtl/reg_bank.sv
// 32 x 32-bit MIPS register bank: R0 is hardwired to zero, one write port, sequenced clear of R1..R31.
// Optional write-through to RegsOut when REG_BANK_BYPASS_EN is defined.
module reg_bank #(
    parameter int DATA_W = 32,
    parameter int N_REGS = 32,
    parameter int ADDR_W = 5
) (
    input  logic        Clk,
    input  logic        Rst,
    reg_bank_if.slave   bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(N_REGS - 1);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     busy_q;
    logic                     wrdrop_q, wrdrop_d;
    logic                     wr_en_s;
    logic                     clr_en_s;
    logic [DATA_W-1:0]        regs_q [N_REGS];
    logic [N_REGS*DATA_W-1:0] regs_out_s;

    // Next-state, clear counter and write/clear strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        clr_en_s = 1'b0;
        wrdrop_d = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en_s = bus.WrEn && (bus.WrAddr != '0);
                if (bus.ClrReq) begin
                    state_d = CLEAR;
                    cnt_d   = CNT_FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                clr_en_s = 1'b1;
                wrdrop_d = bus.WrEn && (bus.WrAddr != '0);
                // Exit on the last register so the counter never wraps onto R0
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_FIRST;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_FIRST;
            end
        endcase
    end

    // State, status flags and register storage
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_FIRST;
            busy_q   <= 1'b0;
            wrdrop_q <= 1'b0;
            for (int k = 0; k < N_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == CLEAR);
            wrdrop_q <= wrdrop_d;
            if (wr_en_s) begin
                regs_q[bus.WrAddr] <= bus.WrData;
            end else if (clr_en_s) begin
                regs_q[cnt_q] <= '0;
            end
        end
    end

    // Flat read bus; R0 slice is tied to zero
    always_comb begin
        regs_out_s = '0;
        for (int k = 1; k < N_REGS; k++) begin
`ifdef REG_BANK_BYPASS_EN
            if ((state_q == IDLE) && bus.WrEn && (bus.WrAddr == ADDR_W'(k))) begin
                regs_out_s[DATA_W*k +: DATA_W] = bus.WrData;
            end else begin
                regs_out_s[DATA_W*k +: DATA_W] = regs_q[k];
            end
`else
            regs_out_s[DATA_W*k +: DATA_W] = regs_q[k];
`endif
        end
    end

    assign bus.RegsOut = regs_out_s;
    assign bus.Busy    = busy_q;
    assign bus.WrDrop  = wrdrop_q;
endmodule
